cnn_conv_sequencer: RTL and testbench
=====================================

# cnn_conv_sequencer

Frame-level controller for the 3×3 binary-convolution lookup datapath, `First_CNN_0`. It accepts a 34×34 1-bit image over a valid/ready stream and drives the datapath's `Din_Valid`/`Din`. It tracks row and column so that `Cal_Valid` is asserted only for windows that lie fully inside the image. It then qualifies the datapath's registered `Dout` as a 32×32 output stream with a last-marker, start/busy/done control and a post-frame flush.

## Interface
Parameters:
- `IMG_W`, 34, image width in pixels; the datapath line buffer is sized 2·IMG_W+3.
- `IMG_H`, 34, image height in pixels.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle frame start; honoured in IDLE only.
- `in_valid` in 1: input pixel valid.
- `in_bit` in 1: input pixel, raster order.
- `in_ready` out 1: pixel accepted when `in_valid && in_ready`.
- `conv_din_valid` out 1: to datapath `Din_Valid`.
- `conv_din` out 1: to datapath `Din`.
- `conv_cal_valid` out 1: to datapath `Cal_Valid`.
- `conv_dout` in 8 signed: from datapath `Dout`.
- `out_valid` out 1: `out_data` valid. There is no backpressure.
- `out_data` out 8 signed: convolution result.
- `out_last` out 1: marks the final result of the frame, index (IMG_H−2)·(IMG_W−2)−1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.

## Operation
States:
- **IDLE**
  - `start` clears the row/col counters, the `pend` register and the output counter, then moves to STREAM.
  - `start` in any other state is ignored.
- **STREAM**
  - `in_ready`=1.
  - On each accept: `conv_din_valid`=1 and `conv_din`=`in_bit`, combinationally, in the same cycle.
  - `col` increments on each accept and wraps at IMG_W−1, which increments `row`.
  - Accepting pixel (IMG_H−1, IMG_W−1) moves to FLUSH.
- **FLUSH**
  - One cycle, `in_ready`=0.
  - `conv_din_valid`=1 with `conv_din`=0. This shifts the datapath window onto the last real pixel.
  - Moves to DRAIN.
- **DRAIN**
  - `in_ready`=0.
  - Waits until the final `out_valid` is issued.
  - In that cycle `done`=1; the next state is IDLE.

Window tagging:
- The datapath window updates one shift after a pixel enters. A window whose bottom-right corner is pixel k is therefore present only after the shift of pixel k+1, or after the flush.
- `pend` register: on each shift (accept or flush), `pend` <= (row≥2 && col≥2) for the pixel being shifted in; the flush shift loads 0.
- `cal_q` register: on each shift, `cal_q` <= old `pend`; otherwise `cal_q` <= 0.
- `conv_cal_valid` = `cal_q`, a one-cycle pulse per valid window.
- `out_valid` = `conv_cal_valid` delayed 1 cycle; `out_data` is taken from `conv_dout` in that cycle.

Output counting and row wrap:
- A 10-bit output counter (⌈log2⌉ of the window count) increments on `out_valid`.
- `out_last` = `out_valid` && count = window count − 1.
- Windows that straddle a row wrap have col<2 and are never tagged.
- Stale line-buffer contents from the previous frame reach only windows with row<2, which are also untagged. The datapath is therefore never cleared between frames.

Boundaries:
- `in_valid` gaps stall everything. `cal_q` is zero on non-shift cycles.
- `rst_n` low mid-frame: return to IDLE, every counter and register cleared, the frame discarded.

Reset values: `in_ready`, `conv_din_valid`, `conv_din`, `conv_cal_valid`, `out_valid`, `out_data`, `out_last`, `busy` and `done` are all 0.

## Timing
- Pixel accepted in cycle t; the next shift happens in cycle t′ ≥ t+1.
  - `conv_cal_valid` is high in t′+1.
  - `out_valid` is high in t′+2.
- Gapless streaming gives a result 3 cycles after its bottom-right pixel is accepted.
- Last pixel accepted in cycle t:
  - FLUSH in t+1.
  - `conv_cal_valid` in t+2.
  - `out_valid`, `out_last` and `done` in t+3.
  - IDLE in t+4.
- Minimum frame time is IMG_W·IMG_H+4 cycles from `start` to IDLE.
- `start` is accepted in the IDLE cycle immediately after `done`.

## Configuration
- `CNN_SEQ_RELU_EN` defined: `out_data` = (`conv_dout` < 0) ? 0 : `conv_dout`.
- `CNN_SEQ_RELU_EN` undefined: `out_data` = `conv_dout` unmodified.
- The macro affects no timing.

## Structure
- Package `cnn_seq_pkg` holds:
  - the state enum (IDLE, STREAM, FLUSH, DRAIN);
  - default IMG_W/IMG_H constants;
  - the window-count constant function (IMG_H−2)·(IMG_W−2);
  - counter width constants.
- One sub-module, `cnn_raster_counter`: row/col counter with enable, clear and an end-of-frame flag.
- FSM, tagging pipeline and output counter stay in the top module.

## Test plan
- All-zero 34×34 frame with the datapath model attached → exactly 1024 `out_valid`, all `out_data`=0, `out_last` only on the 1024th, `done` coincident with it.
- Single 1 at pixel (2,2), rest 0 → first `out_valid` has `out_data`=41 (window 9'b000000001); the remaining 1023 results follow the datapath table for shifted positions.
- Random `in_valid` gaps with ~50% duty → same result sequence as gapless, and `conv_cal_valid` never high on a non-shift cycle +1.
- `start` pulsed during STREAM and DRAIN → ignored, and the frame result count stays 1024.
- `rst_n` asserted at pixel 500 → all outputs 0 immediately. A new `start` with a full frame → 1024 correct results, with no residue from the aborted frame.
- Checks with `CNN_SEQ_RELU_EN`:
  - Forced `conv_dout`=−5 with the macro defined → `out_data`=0.
  - Without the macro → `out_data`=−5 (8'hFB).

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the 3x3 binary-convolution frame sequencer.
package cnn_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  localparam int IMG_W_DEF = 34;
  localparam int IMG_H_DEF = 34;

  // Number of 3x3 windows lying fully inside a w x h image.
  function automatic int win_count(input int w, input int h);
    return (h - 2) * (w - 2);
  endfunction

  localparam int COL_W_DEF  = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF  = $clog2(IMG_H_DEF);
  localparam int OCNT_W_DEF = $clog2(win_count(IMG_W_DEF, IMG_H_DEF));

endpackage

// File: rtl/cnn_raster_counter.sv
// Raster-order row/column tracker; o_eof flags the last pixel position of a frame.
module cnn_raster_counter #(
  parameter int W     = 34,
  parameter int H     = 34,
  parameter int COL_W = $clog2(W),
  parameter int ROW_W = $clog2(H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_eof
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_col_end;
  logic             w_row_end;

  assign w_col_end = (r_col == COL_W'(W - 1));
  assign w_row_end = (r_row == ROW_W'(H - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;
  assign o_eof = w_row_end && w_col_end;

endmodule

// File: rtl/cnn_conv_sequencer.sv
// Frame controller for the First_CNN_0 3x3 binary-convolution datapath.
// Optional build macro CNN_SEQ_RELU_EN clamps negative results to zero.
module cnn_conv_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              conv_din_valid,
  output logic              conv_din,
  output logic              conv_cal_valid,
  input  logic signed [7:0] conv_dout,
  output logic              out_valid,
  output logic signed [7:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int N_WIN  = win_count(IMG_W, IMG_H);
  localparam int OCNT_W = $clog2(N_WIN);

  state_t r_state;
  state_t w_next;

  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic              w_eof;
  logic              w_clr;
  logic              w_accept;
  logic              w_flush;
  logic              w_shift;
  logic              w_tag;
  logic              r_pend;
  logic              r_cal_q;
  logic              r_out_valid;
  logic [OCNT_W-1:0] r_ocnt;
  logic              w_out_last;
  logic signed [7:0] w_data;

  assign w_clr    = (r_state == ST_IDLE) && start;
  assign in_ready = (r_state == ST_STREAM);
  assign w_accept = in_valid && in_ready;
  assign w_flush  = (r_state == ST_FLUSH);
  assign w_shift  = w_accept || w_flush;

  cnn_raster_counter #(
    .W     (IMG_W),
    .H     (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_raster (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_accept),
    .o_row (w_row),
    .o_col (w_col),
    .o_eof (w_eof)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_STREAM;
      ST_STREAM: if (w_accept && w_eof) w_next = ST_FLUSH;
      ST_FLUSH:  w_next = ST_DRAIN;
      ST_DRAIN: begin
        if (w_out_last) begin
          w_next = ST_IDLE;
          done   = 1'b1;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // The datapath window lags one shift behind, so a pixel's tag is released on the following shift.
  assign w_tag = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_cal_q     <= 1'b0;
      r_out_valid <= 1'b0;
      r_ocnt      <= '0;
    end else begin
      r_cal_q     <= w_shift && r_pend;
      r_out_valid <= r_cal_q;
      if (w_clr)         r_pend <= 1'b0;
      else if (w_accept) r_pend <= w_tag;
      else if (w_flush)  r_pend <= 1'b0;
      if (w_clr)            r_ocnt <= '0;
      else if (r_out_valid) r_ocnt <= r_ocnt + 1'b1;
    end
  end

`ifdef CNN_SEQ_RELU_EN
  assign w_data = conv_dout[7] ? 8'sd0 : conv_dout;
`else
  assign w_data = conv_dout;
`endif

  assign w_out_last     = r_out_valid && (r_ocnt == OCNT_W'(N_WIN - 1));
  assign conv_din_valid = w_shift;
  assign conv_din       = w_accept && in_bit;
  assign conv_cal_valid = r_cal_q;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_valid ? w_data : 8'sd0;
  assign out_last       = w_out_last;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Directed bench for cnn_conv_sequencer with a behavioural 3x3 window datapath attached.
module tb_cnn_conv_sequencer;

  localparam int W     = 34;
  localparam int H     = 34;
  localparam int NPIX  = W * H;
  localparam int NWIN  = (H - 2) * (W - 2);
  localparam int LIMIT = 6000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic              conv_din_valid;
  logic              conv_din;
  logic              conv_cal_valid;
  logic signed [7:0] conv_dout;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic              img [0:H-1][0:W-1];
  logic signed [7:0] exp_q [$];

  logic [2*W+3:0]    hist    = '0;
  logic signed [7:0] dp_dout = 8'sd0;
  logic              force_neg = 1'b0;

  cnn_conv_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .in_ready       (in_ready),
    .conv_din_valid (conv_din_valid),
    .conv_din       (conv_din),
    .conv_cal_valid (conv_cal_valid),
    .conv_dout      (conv_dout),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: bit 0 of the window is its bottom-right pixel, bit 8 its top-left.
  function automatic logic signed [7:0] dp_func(input logic [8:0] w);
    logic [15:0] p;
    p = 16'(w) * 16'd41;
    return p[7:0];
  endfunction

  function automatic logic [8:0] dp_win(input logic [2*W+3:0] h);
    logic [8:0] w;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        w[a*3+b] = h[1 + a*W + b];
    return w;
  endfunction

  function automatic logic signed [7:0] post(input logic signed [7:0] v);
`ifdef CNN_SEQ_RELU_EN
    return (v < 0) ? 8'sd0 : v;
`else
    return v;
`endif
  endfunction

  always @(posedge clk) begin
    if (conv_din_valid) hist <= {hist[2*W+2:0], conv_din};
    if (conv_cal_valid) dp_dout <= dp_func(dp_win(hist));
  end

  assign conv_dout = force_neg ? -8'sd5 : dp_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
    if (mode == 1) img[2][2] = 1'b1;
  endtask

  task automatic build_expected();
    logic [8:0] w;
    exp_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            w[a*3+b] = img[r-a][c-b];
        exp_q.push_back(force_neg ? post(-8'sd5) : post(dp_func(w)));
      end
  endtask

  task automatic run_frame(input int gap_pct, input bit glitch, input int abort_at, input bit chk_lat);
    int p = 0, n = 0, cyc = 0;
    int last_acc = -100, acc_22 = -100, first_out = -100, done_cyc = -100;
    bit prev_shift = 1'b0;
    bit fin = 1'b0;
    build_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    while (cyc < LIMIT) begin
      if (conv_cal_valid) check("cal_after_shift", prev_shift, 1);
      if (out_valid) begin
        if (n < NWIN) begin
          check("data", {24'h0, out_data}, {24'h0, exp_q[n]});
          check("last", out_last, n == NWIN - 1);
          check("done_with_last", done, n == NWIN - 1);
        end else begin
          check("extra_result", n, NWIN - 1);
        end
        if (first_out < 0) first_out = cyc;
        if (done) done_cyc = cyc;
        n++;
      end else begin
        check("done_idle", done, 0);
      end
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (p == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {in_ready, conv_din_valid, conv_din, conv_cal_valid, out_valid,
                                out_data, out_last, busy, done}, 0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      start = glitch && (p == 300 || cyc == last_acc + 2);
      if (p < NPIX) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_bit   = img[p / W][p % W];
      end else begin
        in_valid = 1'($urandom_range(1));
        in_bit   = 1'($urandom_range(1));
      end
      #1;
      prev_shift = conv_din_valid;
      if (conv_din_valid && !in_ready) check("flush_din_zero", conv_din, 0);
      if (in_valid && in_ready) begin
        if (p == 2*W + 2) acc_22 = cyc;
        if (p == NPIX - 1) last_acc = cyc;
        p++;
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("frame_finished", fin, 1);
    check("result_count", n, NWIN);
    check("done_latency", done_cyc - last_acc, 3);
    if (chk_lat) check("first_latency", first_out - acc_22, 3);
    @(negedge clk);
    check("idle_after_done", {busy, out_valid, in_ready}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_din_valid", conv_din_valid, 0);
    check("rst_cal_valid", conv_cal_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {24'h0, out_data}, 0);
    check("rst_last_busy_done", {out_last, busy, done}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_no_ready", {in_ready, busy, conv_din_valid}, 0);
    in_valid = 1'b0;

    fill(0); run_frame(0, 1'b0, -1, 1'b1);
    fill(1); run_frame(0, 1'b0, -1, 1'b1);
    check("single_first_41", {24'h0, exp_q[0]}, {24'h0, post(8'sd41)});
    fill(2); run_frame(50, 1'b0, -1, 1'b0);
    fill(2); run_frame(0, 1'b1, -1, 1'b1);
    fill(2); run_frame(0, 1'b0, 500, 1'b0);
    check("abort_idle", busy, 0);
    fill(2); run_frame(0, 1'b0, -1, 1'b1);
    force_neg = 1'b1;
    fill(2); run_frame(0, 1'b0, -1, 1'b0);
    force_neg = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
